// File: rtl/fwd_pkg.sv
// Shared select codes, Tuse sentinel and per-stage tag type for the hazard/forward controller.
package fwd_pkg;

  // Tag address field is sized for the widest register file this unit supports.
  localparam int unsigned TAG_AW = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_M_ALU = 2'b01;
  localparam logic [1:0] FWD_M_PC8 = 2'b10;
  localparam logic [1:0] FWD_W     = 2'b11;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [TAG_AW-1:0] wr_addr;
    logic [1:0]        tnew;
    logic              link;
  } stage_tag_t;

  // M-stage source select: jal/jalr results come from the PC+8 path.
  function automatic logic [1:0] m_sel(input logic link);
    return link ? FWD_M_PC8 : FWD_M_ALU;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads the unit latency on a start, counts down to idle.
module md_busy_counter #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy_c
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= i_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy_c = (r_count != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Stateful hazard/forward controller for the 5-stage MIPS pipeline.
// Define HAZARD_FWD_MD_EN to compile in the HI/LO busy counter and its stall term.
module hazard_forward_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs_addr,
  input  logic [REG_AW-1:0] d_rt_addr,
  input  logic [1:0]        d_rs_tuse,
  input  logic [1:0]        d_rt_tuse,
  input  logic [REG_AW-1:0] d_wr_addr,
  input  logic [1:0]        d_tnew,
  input  logic              d_link,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
);

  stage_tag_t        r_e_tag, r_m_tag, r_w_tag;
  logic [REG_AW-1:0] r_e_rs, r_e_rt, r_m_rs, r_m_rt;

  stage_tag_t w_d_tag, w_m_next;
  logic       w_rs_e_hit, w_rs_m_hit, w_rt_e_hit, w_rt_m_hit;
  logic       w_haz_rs, w_haz_rt;
  logic       w_md_busy, w_md_stall, w_stall;
  logic       w_unused;

  // Register $0 never produces a match.
  function automatic logic tag_hit(input logic [REG_AW-1:0] src, input stage_tag_t tag);
    return (src != '0) && (TAG_AW'(src) == tag.wr_addr);
  endfunction

  assign w_d_tag  = '{wr_addr: TAG_AW'(d_wr_addr), tnew: d_tnew, link: d_link};
  assign w_m_next = '{wr_addr: r_e_tag.wr_addr,
                      tnew:    (r_e_tag.tnew == 2'd0) ? 2'd0 : r_e_tag.tnew - 2'd1,
                      link:    r_e_tag.link};

  // E captures D or a bubble; M and W shift unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_tag <= '0;
      r_e_rs  <= '0;
      r_e_rt  <= '0;
      r_m_tag <= '0;
      r_m_rs  <= '0;
      r_m_rt  <= '0;
      r_w_tag <= '0;
    end else begin
      if (w_stall) begin
        r_e_tag <= '0;
        r_e_rs  <= '0;
        r_e_rt  <= '0;
      end else begin
        r_e_tag <= w_d_tag;
        r_e_rs  <= d_rs_addr;
        r_e_rt  <= d_rt_addr;
      end
      r_m_tag <= w_m_next;
      r_m_rs  <= r_e_rs;
      r_m_rt  <= r_e_rt;
      r_w_tag <= '{wr_addr: r_m_tag.wr_addr, tnew: 2'd0, link: r_m_tag.link};
    end
  end

  // D-stage matches, stall terms and all forward selects.
  always_comb begin
    w_rs_e_hit = 1'b0;
    w_rs_m_hit = 1'b0;
    w_rt_e_hit = 1'b0;
    w_rt_m_hit = 1'b0;
    w_haz_rs   = 1'b0;
    w_haz_rt   = 1'b0;
    fwd_rs_d   = FWD_RF;
    fwd_rt_d   = FWD_RF;
    fwd_rs_e   = FWD_RF;
    fwd_rt_e   = FWD_RF;
    fwd_rt_m   = 1'b0;

    w_rs_e_hit = (d_rs_tuse != TUSE_NONE) && tag_hit(d_rs_addr, r_e_tag);
    w_rs_m_hit = (d_rs_tuse != TUSE_NONE) && tag_hit(d_rs_addr, r_m_tag);
    w_rt_e_hit = (d_rt_tuse != TUSE_NONE) && tag_hit(d_rt_addr, r_e_tag);
    w_rt_m_hit = (d_rt_tuse != TUSE_NONE) && tag_hit(d_rt_addr, r_m_tag);

    // Tuse 0 cannot be served from E: no E->D path exists.
    w_haz_rs = (w_rs_e_hit && ((r_e_tag.tnew > d_rs_tuse) || (d_rs_tuse == 2'd0)))
            || (w_rs_m_hit && (r_m_tag.tnew > d_rs_tuse));
    w_haz_rt = (w_rt_e_hit && ((r_e_tag.tnew > d_rt_tuse) || (d_rt_tuse == 2'd0)))
            || (w_rt_m_hit && (r_m_tag.tnew > d_rt_tuse));

    if (w_rs_m_hit) fwd_rs_d = m_sel(r_m_tag.link);
    if (w_rt_m_hit) fwd_rt_d = m_sel(r_m_tag.link);

    if (tag_hit(r_e_rs, r_m_tag))      fwd_rs_e = m_sel(r_m_tag.link);
    else if (tag_hit(r_e_rs, r_w_tag)) fwd_rs_e = FWD_W;

    if (tag_hit(r_e_rt, r_m_tag))      fwd_rt_e = m_sel(r_m_tag.link);
    else if (tag_hit(r_e_rt, r_w_tag)) fwd_rt_e = FWD_W;

    fwd_rt_m = tag_hit(r_m_rt, r_w_tag);
  end

`ifdef HAZARD_FWD_MD_EN
  md_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (d_md_start & ~w_stall),
    .i_div    (d_md_div),
    .o_busy_c (w_md_busy)
  );
  assign w_md_stall = d_md_use & w_md_busy;
  assign w_unused   = ^{r_m_rs, r_w_tag.tnew, r_w_tag.link};
`else
  assign w_md_busy  = 1'b0;
  assign w_md_stall = 1'b0;
  assign w_unused   = ^{r_m_rs, r_w_tag.tnew, r_w_tag.link, d_md_start, d_md_div, d_md_use,
                        32'(MUL_LAT), 32'(DIV_LAT)};
`endif

  assign w_stall = w_haz_rs | w_haz_rt | w_md_stall;
  assign stall   = w_stall;
  assign md_busy = w_md_busy;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pipeline scenarios plus random traffic against an in-flight list model.
module tb_hazard_forward_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;
`ifdef HAZARD_FWD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [REG_AW-1:0] d_rs_addr, d_rt_addr, d_wr_addr;
  logic [1:0]        d_rs_tuse, d_rt_tuse, d_tnew;
  logic              d_link, d_md_start, d_md_div, d_md_use;
  logic              stall, fwd_rt_m, md_busy;
  logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_AW  (REG_AW),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_wr_addr  (d_wr_addr),
    .d_tnew     (d_tnew),
    .d_link     (d_link),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m),
    .md_busy    (md_busy)
  );

  // In-flight instructions by age since entering E: 0 = E, 1 = M, 2 = W.
  typedef struct {
    int wr;
    int tnew;
    bit link;
    int rs;
    int rt;
  } instr_t;

  instr_t pipe [3];
  int     cyc;
  int     md_done;
  int     n_checks;
  int     n_fail;
  bit     exp_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic bit hit(input int addr, input int s);
    return (addr != 0) && (addr == pipe[s].wr);
  endfunction

  // Cycles still needed before the result exists, given how long ago it entered E.
  function automatic int left(input int s);
    return (pipe[s].tnew > s) ? pipe[s].tnew - s : 0;
  endfunction

  function automatic bit src_stall(input int addr, input int tuse);
    if (tuse == 3) return 1'b0;
    if (hit(addr, 0) && ((left(0) > tuse) || (tuse == 0))) return 1'b1;
    return hit(addr, 1) && (left(1) > tuse);
  endfunction

  function automatic int sel_m();
    return pipe[1].link ? 2 : 1;
  endfunction

  function automatic int exp_fwd_d(input int addr, input int tuse);
    return (tuse != 3 && hit(addr, 1)) ? sel_m() : 0;
  endfunction

  function automatic int exp_fwd_e(input int addr);
    if (hit(addr, 1)) return sel_m();
    if (hit(addr, 2)) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    foreach (pipe[i]) pipe[i] = '{0, 0, 1'b0, 0, 0};
    md_done = 0;
  endtask

  task automatic set_d(input int rs, input int rt, input int rs_tu, input int rt_tu,
                       input int wr, input int tnew, input bit link,
                       input bit md_start = 1'b0, input bit md_div = 1'b0, input bit md_use = 1'b0);
    d_rs_addr  = REG_AW'(rs);
    d_rt_addr  = REG_AW'(rt);
    d_rs_tuse  = 2'(rs_tu);
    d_rt_tuse  = 2'(rt_tu);
    d_wr_addr  = REG_AW'(wr);
    d_tnew     = 2'(tnew);
    d_link     = link;
    d_md_start = md_start;
    d_md_div   = md_div;
    d_md_use   = md_use;
  endtask

  task automatic set_nop();
    set_d(0, 0, 3, 3, 0, 0, 1'b0);
  endtask

  task automatic rand_d();
    bit st;
    st = ($urandom_range(0, 9) == 0);
    set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          ($urandom_range(0, 7) == 0), st, bit'($urandom_range(0, 1)),
          st || ($urandom_range(0, 7) == 0));
  endtask

  // Compare every output against the model mid-cycle.
  task automatic sample();
    bit busy;
    @(negedge clk);
    busy = MD_EN && (cyc < md_done);
    exp_stall = src_stall(int'(d_rs_addr), int'(d_rs_tuse))
             || src_stall(int'(d_rt_addr), int'(d_rt_tuse))
             || (busy && d_md_use);
    check_eq("stall",    32'(stall),    32'(exp_stall));
    check_eq("fwd_rs_d", 32'(fwd_rs_d), 32'(exp_fwd_d(int'(d_rs_addr), int'(d_rs_tuse))));
    check_eq("fwd_rt_d", 32'(fwd_rt_d), 32'(exp_fwd_d(int'(d_rt_addr), int'(d_rt_tuse))));
    check_eq("fwd_rs_e", 32'(fwd_rs_e), 32'(exp_fwd_e(pipe[0].rs)));
    check_eq("fwd_rt_e", 32'(fwd_rt_e), 32'(exp_fwd_e(pipe[0].rt)));
    check_eq("fwd_rt_m", 32'(fwd_rt_m), 32'(pipe[2].wr != 0 && pipe[2].wr == pipe[1].rt));
    check_eq("md_busy",  32'(md_busy),  32'(busy));
  endtask

  // Advance the model across one rising edge, then let inputs be redriven.
  task automatic clock();
    instr_t n;
    @(posedge clk);
    if (exp_stall) n = '{0, 0, 1'b0, 0, 0};
    else n = '{int'(d_wr_addr), int'(d_tnew), d_link, int'(d_rs_addr), int'(d_rt_addr)};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
    cyc++;
    if (MD_EN && !exp_stall && d_md_start)
      md_done = cyc + int'(d_md_div ? DIV_LAT : MUL_LAT);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    exp_stall = 1'b0;
    model_reset();
    reset_n = 1'b0;
    set_nop();

    // Reset state
    sample();
    check_eq("rst_stall",   32'(stall),   32'd0);
    check_eq("rst_md_busy", 32'(md_busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // lw $2 then addu $3,$2,$2
    set_d(1, 0, 1, 3, 2, 2, 1'b0);
    sample(); clock();
    set_d(2, 2, 1, 1, 3, 1, 1'b0);
    sample(); check_eq("lw_use_stall", 32'(stall), 32'd1); clock();
    sample(); check_eq("lw_use_release", 32'(stall), 32'd0); clock();
    set_nop();
    sample();
    check_eq("lw_use_fwd_rs_e", 32'(fwd_rs_e), 32'd3);
    check_eq("lw_use_fwd_rt_e", 32'(fwd_rt_e), 32'd3);
    clock();

    // addu $4 then beq $4,$0
    set_d(5, 6, 1, 1, 4, 1, 1'b0);
    sample(); clock();
    set_d(4, 0, 0, 0, 0, 0, 1'b0);
    sample(); check_eq("beq_stall", 32'(stall), 32'd1); clock();
    sample();
    check_eq("beq_release",  32'(stall),    32'd0);
    check_eq("beq_fwd_rs_d", 32'(fwd_rs_d), 32'd1);
    check_eq("beq_fwd_rt_d", 32'(fwd_rt_d), 32'd0);
    clock();

    // jal then jr $31
    set_d(0, 0, 3, 3, 31, 0, 1'b1);
    sample(); clock();
    set_d(31, 0, 0, 3, 0, 0, 1'b0);
    sample(); check_eq("jr_stall", 32'(stall), 32'd1); clock();
    sample();
    check_eq("jr_release",  32'(stall),    32'd0);
    check_eq("jr_fwd_rs_d", 32'(fwd_rs_d), 32'd2);
    clock();

    // Writes to $0 never match
    set_nop();
    for (int i = 0; i < 3; i++) begin sample(); clock(); end
    set_d(0, 0, 1, 1, 0, 1, 1'b0);
    sample(); clock();
    set_d(0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("r0_stall", 32'(stall), 32'd0);
      check_eq("r0_fwd", 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}), 32'd0);
      clock();
    end

`ifdef HAZARD_FWD_MD_EN
    // mult then mflo
    set_nop();
    sample(); clock();
    set_d(7, 8, 1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    sample(); clock();
    set_d(0, 0, 3, 3, 9, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      sample();
      check_eq("mflo_md_busy", 32'(md_busy), 32'd1);
      check_eq("mflo_stall",   32'(stall),   32'd1);
      clock();
    end
    sample();
    check_eq("mflo_release", 32'(stall),   32'd0);
    check_eq("mflo_idle",    32'(md_busy), 32'd0);
    clock();
`endif

    // Reset mid-stall, during an MD count
    set_d(7, 8, 1, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    sample(); clock();
    set_d(1, 0, 1, 3, 2, 2, 1'b0);
    sample(); clock();
    set_d(2, 2, 1, 1, 3, 1, 1'b0);
    sample();
    check_eq("pre_rst_stall", 32'(stall), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_stall",   32'(stall),   32'd0);
    check_eq("async_rst_md_busy", 32'(md_busy), 32'd0);
    check_eq("async_rst_fwd", 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}), 32'd0);
    model_reset();
    exp_stall = 1'b0;
    @(posedge clk);
    #1;
    set_nop();
    reset_n = 1'b1;

    // Random traffic; D is held while stalled
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall) rand_d();
      sample();
      clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised successor to the per-stage forward muxes: a stateful hazard and forwarding controller for the 5-stage MIPS pipeline. It tracks the destination tag, Tnew and link flag of every in-flight instruction in internal E/M/W shift registers. From these it drives the select codes for the D/E/M forward muxes and the pipeline stall. An optional multiply/divide busy counter adds HI/LO hazard stalls.

## Interface
- REG_AW, 5, register address width
- MUL_LAT, 5, cycles the MD unit stays busy after a mult/multu enters E
- DIV_LAT, 10, cycles the MD unit stays busy after a div/divu enters E
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- d_rs_addr, d_rt_addr  in  REG_AW each  D-stage source registers
- d_rs_tuse, d_rt_tuse  in  2 each  Tuse 0/1/2; 3 means the source is not read
- d_wr_addr  in  REG_AW  D-stage destination; 0 means no write
- d_tnew  in  2  Tnew of the D instruction as measured at E
- d_link  in  1  result is PC+8 (jal/jalr)
- d_md_start, d_md_div  in  1 each  D instruction starts the MD unit; div when set
- d_md_use  in  1  D instruction touches MD/HI/LO
- stall  out  1  freeze PC and IF/ID, bubble ID/EX
- fwd_rs_d, fwd_rt_d  out  2 each  D forward select
- fwd_rs_e, fwd_rt_e  out  2 each  E forward select
- fwd_rt_m  out  1  M store-data forward from W
- md_busy  out  1  MD unit busy

## Operation
- Select encoding for 2-bit outputs: 00 regfile/pipe, 01 M ALU result, 10 M PC+8, 11 W result.
- Tag registers per stage: wr_addr, tnew, link. E and M also hold rs/rt addresses.
- On a non-stall edge, D is captured into E. On a stall edge, E loads a bubble: all fields zero, source addresses zero.
- M and W always shift.
- tnew_m = tnew_e − 1, saturating at 0. W tnew is always 0.
- A match requires the source address to equal the stage wr_addr, the address to be nonzero, and Tuse ≠ 3.
- stall is the OR of the following conditions:
  - E match with tnew_e > tuse.
  - M match with tnew_m > tuse.
  - E match with tuse = 0. There is no E→D forward path.
  - With the MD feature: d_md_use & md_busy.
- fwd_*_d:
  - M match gives 01, or 10 if link_m is set.
  - Otherwise 00. W→D bypass belongs to the regfile.
- fwd_*_e, using E-stage addresses:
  - M match gives 01/10 by link_m.
  - Otherwise a W match gives 11.
  - Otherwise 00.
  - The youngest stage wins.
- fwd_rt_m: W wr_addr equals the M rt address and is nonzero.
- All selects and stall are combinational from the tag registers and D inputs.

## Timing
- Tag registers update on the rising clk edge. reset_n low clears all of them immediately and asynchronously.
- Reset values: stall 0, every fwd output 0, md_busy 0. These hold while reset_n is low, since zero tags never match.
- Stall latency is 0 cycles: stall is asserted in the same cycle the hazard is visible in D.
- MD counter width is $clog2(DIV_LAT+1).
- On a non-stall edge with d_md_start, the counter loads MUL_LAT, or DIV_LAT when d_md_div is set.
- Otherwise the counter decrements when nonzero, stall or not. md_busy = (count ≠ 0).
- A new start while busy reloads the counter. The bench must not issue one, because d_md_use stalls it first.
- Reset mid-count clears the counter at once.
- Simultaneous events:
  - A hazard on both rs and rt gives a single stall.
  - An M match and a W match on the same source select M.

## Configuration
- HAZARD_FWD_MD_EN defined: the MD busy counter and its stall term are compiled in.
- Undefined: no counter is synthesised, md_busy is tied to 0, and d_md_start/d_md_div/d_md_use are ignored.

## Structure
- The shared package fwd_pkg holds:
  - FWD_RF=2'b00, FWD_M_ALU=2'b01, FWD_M_PC8=2'b10, FWD_W=2'b11, TUSE_NONE=2'd3.
  - A stage-tag struct typedef {wr_addr, tnew, link}.
- Sub-module md_busy_counter, parameters MUL_LAT/DIV_LAT: load, decrement, busy. It is instantiated only under HAZARD_FWD_MD_EN.

## Test plan
- lw $2 (tnew 2) then addu $3,$2,$2 (tuse 1): stall=1 for exactly 1 cycle. The next cycle shows stall=0. Once addu is in E, fwd_rs_e=fwd_rt_e=11.
- addu $4 (tnew 1) then beq $4,$0 (tuse 0): stall=1 for 1 cycle, then fwd_rs_d=01 and fwd_rt_d=00.
- jal (wr 31, link, tnew 0) then jr $31 (tuse 0): 1-cycle stall, then fwd_rs_d=10.
- addu $0 followed by a reader of $0 at tuse 0: stall never asserts and all fwd selects stay 00.
- With HAZARD_FWD_MD_EN and MUL_LAT=5: mult then mflo. md_busy stays high for 5 cycles after mult enters E, and stall=1 during each of those cycles.
- Drive reset_n low mid-stall, during an MD count: stall, md_busy and every fwd output are 0 before the next clk edge.
